// File: rtl/xge_rx_frm_cap.sv
// xge_rx_frm_cap: captures one XGMII frame (DA..FCS) into a byte buffer with word readback
module xge_rx_frm_cap #(
    parameter int MAX_BYTES = 512,
    parameter int ADDR_W    = 7
) (
    input  logic              rx_clk,
    input  logic              rx_rst,
    input  logic [63:0]       xge_rxd_i,
    input  logic [7:0]        xge_rxc_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o,
    output logic              frm_valid_o,
    output logic [9:0]        frm_len_o,
    input  logic              frm_ack_i,
    output logic              err_o,
    output logic [15:0]       frm_cnt_o,
    output logic [15:0]       drop_cnt_o
);
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_PRE   = 8'h55;
    localparam logic [7:0] C_SFD   = 8'hD5;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DROP, S_HOLD} state_t;

    state_t              r_state, w_nxt;
    logic [9:0]          r_cnt, w_cnt_nxt;
    logic [7:0]          r_mem [MAX_BYTES];
    logic                w_start, w_bad_start, w_term;
    logic [2:0]          w_k;
    logic [3:0]          w_nbytes;
    logic [10:0]         w_sum;
    logic [7:0]          w_we;
    logic                w_err, w_cap, w_drop;
    logic [ADDR_W+1:0]   w_base;

    assign w_start     = xge_rxc_i == 8'h01 && xge_rxd_i[7:0] == C_START &&
                         xge_rxd_i[55:8] == {6{C_PRE}} && xge_rxd_i[63:56] == C_SFD;
    assign w_bad_start = xge_rxc_i[0] && xge_rxd_i[7:0] == C_START && !w_start;
    assign w_term      = xge_rxd_i[8*w_k +: 8] == C_TERM && xge_rxc_i == (8'hFF << w_k);
    assign w_nbytes    = (xge_rxc_i == 8'h00) ? 4'd8 : {1'b0, w_k};
    assign w_sum       = {1'b0, r_cnt} + 11'(w_nbytes);
    assign w_base      = r_cnt[ADDR_W+1:0];

    // lowest control lane in the current word
    always_comb begin
        w_k = 3'd0;
        for (int j = 7; j >= 0; j--)
            if (xge_rxc_i[j]) w_k = 3'(j);
    end

    // next-state, byte enables and event strobes
    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_we      = 8'h00;
        w_err     = 1'b0;
        w_cap     = 1'b0;
        w_drop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nxt     = S_DATA;
                    w_cnt_nxt = 10'd0;
                end else if (w_bad_start) begin
                    w_err  = 1'b1;
                    w_drop = 1'b1;
                end
            end
            S_DATA: begin
                if (xge_rxc_i != 8'h00 && !w_term) begin
                    w_err  = 1'b1;
                    w_drop = 1'b1;
                    w_nxt  = S_IDLE;
                end else if (w_sum > 11'(MAX_BYTES)) begin
                    w_err  = 1'b1;
                    w_drop = 1'b1;
                    w_nxt  = S_DROP;
                end else begin
                    w_we      = (xge_rxc_i == 8'h00) ? 8'hFF : ~(8'hFF << w_k);
                    w_cnt_nxt = w_sum[9:0];
                    if (xge_rxc_i != 8'h00) begin
                        w_cap = 1'b1;
                        w_nxt = S_HOLD;
                    end
                end
            end
            S_DROP: w_nxt = (xge_rxc_i != 8'h00) ? S_IDLE : S_DROP;
            S_HOLD: begin
                w_drop = w_start;
                w_nxt  = frm_ack_i ? S_IDLE : S_HOLD;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // state, counters, status outputs and registered readback
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 10'd0;
            frm_valid_o <= 1'b0;
            frm_len_o   <= 10'd0;
            err_o       <= 1'b0;
            frm_cnt_o   <= 16'd0;
            drop_cnt_o  <= 16'd0;
            rd_data_o   <= 32'd0;
        end else begin
            r_state     <= w_nxt;
            r_cnt       <= w_cnt_nxt;
            frm_valid_o <= w_nxt == S_HOLD;
            err_o       <= w_err;
            frm_cnt_o   <= frm_cnt_o + 16'(w_cap);
            drop_cnt_o  <= drop_cnt_o + 16'(w_drop);
            if (w_cap) frm_len_o <= w_cnt_nxt;
            if (rd_en_i)
                rd_data_o <= {r_mem[{rd_addr_i, 2'd3}], r_mem[{rd_addr_i, 2'd2}],
                              r_mem[{rd_addr_i, 2'd1}], r_mem[{rd_addr_i, 2'd0}]};
        end
    end

    // frame buffer, one byte lane per enable, no reset
    always_ff @(posedge rx_clk) begin
        for (int j = 0; j < 8; j++)
            if (w_we[j]) r_mem[w_base + (ADDR_W+2)'(j)] <= xge_rxd_i[8*j +: 8];
    end
endmodule

// File: tb/tb_xge_rx_frm_cap.sv
// tb_xge_rx_frm_cap: directed checks of frame capture, errors, overflow, hold and reset
module tb_xge_rx_frm_cap;
    localparam logic [63:0] IDLEW = {8{8'h07}};
    localparam logic [63:0] STARTW = 64'hD555_5555_5555_55FB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rxd = IDLEW;
    logic [7:0]  rxc = 8'hFF;
    logic        rd_en = 1'b0;
    logic [6:0]  rd_addr = 7'd0;
    logic [31:0] rd_data;
    logic        frm_valid;
    logic [9:0]  frm_len;
    logic        frm_ack = 1'b0;
    logic        err;
    logic [15:0] frm_cnt, drop_cnt;
    int          total = 0, bad = 0, n_err = 0;
    logic [31:0] d;

    xge_rx_frm_cap dut (
        .rx_clk(clk), .rx_rst(rst), .xge_rxd_i(rxd), .xge_rxc_i(rxc),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .frm_valid_o(frm_valid), .frm_len_o(frm_len), .frm_ack_i(frm_ack),
        .err_o(err), .frm_cnt_o(frm_cnt), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [63:0] dw, input logic [7:0] cw);
        @(negedge clk);
        rxd = dw;
        rxc = cw;
    endtask

    task automatic idle(input int n);
        repeat (n) put(IDLEW, 8'hFF);
    endtask

    function automatic logic [63:0] dword(input int off, input logic [7:0] base);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(base + off + j);
        return r;
    endfunction

    task automatic body(input int len, input logic [7:0] base, input int from_word);
        logic [63:0] t;
        int k;
        for (int w = from_word; w < len / 8; w++) put(dword(8 * w, base), 8'h00);
        k = len % 8;
        t = IDLEW;
        for (int j = 0; j < k; j++) t[8*j +: 8] = 8'(base + len - k + j);
        t[8*k +: 8] = 8'hFD;
        put(t, 8'hFF << k);
    endtask

    task automatic send(input int len, input logic [7:0] base);
        put(STARTW, 8'h01);
        body(len, base, 0);
        idle(1);
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        @(negedge clk);
        rd_en = 1'b1;
        rd_addr = 7'(a);
        @(negedge clk);
        rd_en = 1'b0;
        v = rd_data;
    endtask

    task automatic ack();
        @(negedge clk);
        frm_ack = 1'b1;
        @(negedge clk);
        frm_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] sweep_word(input int w, input int len);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            int n = 4 * w + j;
            r[8*j +: 8] = (n < len) ? 8'(8'h80 + n) : 8'(n);
        end
        return r;
    endfunction

    initial begin
        idle(2);
        check("rst_valid", 32'(frm_valid), 0);
        check("rst_len", 32'(frm_len), 0);
        check("rst_rd", rd_data, 0);
        check("rst_err", 32'(err), 0);
        check("rst_cnt", {frm_cnt, drop_cnt}, 0);
        rst = 1'b0;
        idle(2);

        send(64, 8'h00);
        check("f64_valid", 32'(frm_valid), 1);
        check("f64_len", 32'(frm_len), 64);
        check("f64_cnt", 32'(frm_cnt), 1);
        rd(0, d);  check("f64_w0", d, 32'h03020100);
        rd(15, d); check("f64_w15", d, 32'h3F3E3D3C);
        ack();
        check("ack_valid", 32'(frm_valid), 0);
        check("ack_len_kept", 32'(frm_len), 64);

        for (int len = 60; len <= 67; len++) begin
            send(72, 8'h00);
            ack();
            send(len, 8'h80);
            check($sformatf("sw%0d_len", len), 32'(frm_len), 32'(len));
            rd((len - 1) / 4, d);
            check($sformatf("sw%0d_last", len), d, sweep_word((len - 1) / 4, len));
            rd((len - 1) / 4 + 1, d);
            check($sformatf("sw%0d_after", len), d, sweep_word((len - 1) / 4 + 1, len));
            ack();
        end
        check("sw_cnt", 32'(frm_cnt), 17);
        check("sw_noerr", 32'(n_err), 0);

        do_reset();
        n_err = 0;
        put(64'hD555_5555_5455_55FB, 8'h01);
        body(32, 8'h10, 0);
        idle(2);
        check("pre_err", 32'(n_err), 1);
        check("pre_drop", 32'(drop_cnt), 1);
        check("pre_valid", 32'(frm_valid), 0);
        send(24, 8'h40);
        check("pre_next_valid", 32'(frm_valid), 1);
        check("pre_next_len", 32'(frm_len), 24);
        rd(0, d); check("pre_next_w0", d, 32'h43424140);

        do_reset();
        n_err = 0;
        send(520, 8'h00);
        idle(1);
        check("ovf_err", 32'(n_err), 1);
        check("ovf_drop", 32'(drop_cnt), 1);
        check("ovf_valid", 32'(frm_valid), 0);
        check("ovf_cnt", 32'(frm_cnt), 0);
        send(16, 8'h00);
        check("ovf_next_valid", 32'(frm_valid), 1);
        check("ovf_next_len", 32'(frm_len), 16);

        do_reset();
        n_err = 0;
        send(64, 8'h00);
        send(32, 8'h40);
        check("hold_drop", 32'(drop_cnt), 1);
        check("hold_noerr", 32'(n_err), 0);
        check("hold_len", 32'(frm_len), 64);
        check("hold_valid", 32'(frm_valid), 1);
        rd(0, d);  check("hold_w0", d, 32'h03020100);
        rd(15, d); check("hold_w15", d, 32'h3F3E3D3C);
        ack();
        send(48, 8'h20);
        check("hold_c_cnt", 32'(frm_cnt), 2);
        check("hold_c_len", 32'(frm_len), 48);
        rd(0, d); check("hold_c_w0", d, 32'h23222120);

        do_reset();
        send(40, 8'h00);
        rd(1, d);
        put(STARTW, 8'h01);
        for (int w = 0; w < 3; w++) put(dword(8 * w, 8'h60), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out", {frm_cnt, drop_cnt}, 0);
        check("mid_rst_len", 32'(frm_len), 0);
        check("mid_rst_rd", rd_data, 0);
        check("mid_rst_valid", 32'(frm_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        body(64, 8'h60, 4);
        idle(2);
        check("mid_rest_ign", 32'(frm_valid), 0);
        send(16, 8'hA0);
        check("mid_next_cnt", 32'(frm_cnt), 1);
        check("mid_next_len", 32'(frm_len), 16);
        rd(3, d); check("mid_next_w3", d, 32'hAFAEADAC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
